psr_cond_unit: RTL and testbench
================================

Name: psr_cond_unit

Overview:
- Flag/condition stage directly downstream of the ARM ALU in the EX stage.
- Holds the architectural N/Z/C/V status flags and updates them from the ALU flag outputs when the EX instruction has its S bit set.
- Feeds the registered C flag back to the ALU carry-in.
- Evaluates the 4-bit ARM condition field of the instruction in ID (with EX→ID flag forwarding) and registers pass/branch-taken results into ID/EX; also keeps a saturating condition-fail counter.

Parameters:
- FWD_EN, 1, 1 = forward the EX-stage ALU flags into the ID condition check; 0 = use registered flags only.
- CNT_W, 16, width of the saturating condition-fail counter.

Ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- alu_n, alu_z, alu_c, alu_v  in  1 each  flag outputs of the ALU for the EX instruction.
- ex_valid  in  1  EX stage holds a real instruction.
- ex_s  in  1  EX instruction writes flags (S bit).
- id_valid  in  1  ID stage holds a real instruction.
- id_cond  in  4  ARM condition field of the ID instruction.
- id_is_branch  in  1  ID instruction is B/BL.
- stall  in  1  pipeline stall; holds all state.
- flush  in  1  kill the ID instruction; clears ID/EX outputs.
- flags_q  out  4  {N,Z,C,V} architectural flags.
- alu_cin  out  1  equals flags_q C bit; drives ALU CIN.
- cond_pass_q  out  1  registered: ID instruction passed its condition.
- br_taken_q  out  1  registered: ID branch passed its condition.
- fail_cnt  out  CNT_W  saturating count of valid instructions that failed their condition.

Behaviour:
- Reset (reset_n=0, asynchronous, any time including mid-stall): flags_q=4'b0000, alu_cin=0, cond_pass_q=0, br_taken_q=0, fail_cnt=0. Takes effect immediately, not at the next edge.
- Flag write (we): we = ex_valid & ex_s & ~stall. When we=1, flags_q <= {alu_n,alu_z,alu_c,alu_v} at the rising edge; otherwise flags_q holds. One-cycle latency.
- alu_cin is combinational from flags_q. An ADC/SBC in EX sees the C written by the preceding instruction, never its own result.
- Effective flags fN,fZ,fC,fV = ALU inputs when FWD_EN=1 and ex_valid & ex_s = 1; otherwise flags_q.
- Condition function pass(id_cond), evaluated on effective flags:
  - EQ 0000: Z
  - NE 0001: !Z
  - CS 0010: C
  - CC 0011: !C
  - MI 0100: N
  - PL 0101: !N
  - VS 0110: V
  - VC 0111: !V
  - HI 1000: C&!Z
  - LS 1001: !C|Z
  - GE 1010: N==V
  - LT 1011: N!=V
  - GT 1100: !Z&(N==V)
  - LE 1101: Z|(N!=V)
  - AL 1110: 1
  - 1111: 0 (unsupported)
- ID/EX register update at the rising edge, with priority flush > stall > normal:
  - flush=1: cond_pass_q<=0, br_taken_q<=0.
  - stall=1 (no flush): both hold.
  - Otherwise: cond_pass_q <= id_valid & pass; br_taken_q <= id_valid & id_is_branch & pass.
- fail_cnt: increments by 1 on a normal (no stall, no flush) edge with id_valid=1 and pass=0. Saturates at all-ones and never wraps. Holds on stall or flush.
- Flush does not block a flag write; stall does. Simultaneous flag write and ID evaluation uses forwarded values (FWD_EN=1).
- The ID/EX state machine is implicit (registered outputs only). No additional FSM states.

Test Plan:
- Reset: assert reset_n=0 mid-run with flags_q=4'b1111 and fail_cnt=5 → all outputs 0 immediately, before any clock edge.
- Flag capture: ex_valid=1, ex_s=1, ALU flags N=0 Z=0 C=1 V=1 (0x9C000038−0x70000003=0x2C000035) → next edge flags_q=4'b0011, alu_cin=1. Repeat with ex_s=0 and different ALU flags → flags_q unchanged.
- Forwarding: flags_q=0000; same cycle EX writes N0 Z0 C1 V1 and ID holds GE(1010), id_valid=1 → cond_pass_q=0, fail_cnt+1. With LT/HI/VS → cond_pass_q=1. With FWD_EN=0 and GE → pass=1 (uses N=V=0).
- Branch: id_is_branch=1, id_cond=EQ, Z=1 → br_taken_q=1 one cycle later. Same with flush=1 → br_taken_q=0 and fail_cnt unchanged.
- Stall: stall=1 with ex_s=1 and new ALU flags, and ID cond failing → flags_q, cond_pass_q and fail_cnt all hold. Release stall → update on the next edge.
- Saturation and 1111: CNT_W=4, present 20 valid id_cond=1111 instructions → fail_cnt stops at 15.

Source files
------------

// File: rtl/psr_cond_unit_if.sv
// Bus between the EX/ID pipeline control and the flag/condition stage.
// The pipeline side is the master: it supplies ALU flags and the ID
// instruction's condition. The condition unit is the slave: it returns the
// registered flags, the ALU carry-in and the ID/EX condition results.
interface psr_cond_unit_if #(
    parameter int CNT_W = 16
);
    logic             alu_n;
    logic             alu_z;
    logic             alu_c;
    logic             alu_v;
    logic             ex_valid;
    logic             ex_s;
    logic             id_valid;
    logic [3:0]       id_cond;
    logic             id_is_branch;
    logic             stall;
    logic             flush;

    logic [3:0]       flags_q;
    logic             alu_cin;
    logic             cond_pass_q;
    logic             br_taken_q;
    logic [CNT_W-1:0] fail_cnt;

    modport master (
        output alu_n, alu_z, alu_c, alu_v,
        output ex_valid, ex_s,
        output id_valid, id_cond, id_is_branch,
        output stall, flush,
        input  flags_q, alu_cin, cond_pass_q, br_taken_q, fail_cnt
    );

    modport slave (
        input  alu_n, alu_z, alu_c, alu_v,
        input  ex_valid, ex_s,
        input  id_valid, id_cond, id_is_branch,
        input  stall, flush,
        output flags_q, alu_cin, cond_pass_q, br_taken_q, fail_cnt
    );
endinterface

// File: rtl/psr_cond_unit.sv
// Flag/condition stage downstream of the ALU in EX.
// Holds the architectural N/Z/C/V flags, feeds C back as the ALU carry-in,
// evaluates the ID instruction's ARM condition on (optionally forwarded)
// flags and registers the pass / branch-taken results into ID/EX.
// A saturating counter tracks valid instructions that failed their condition.
// The ID/EX side has no explicit state machine: it is registered outputs only.
module psr_cond_unit #(
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    psr_cond_unit_if.slave  bus
);

    logic [3:0]       flags_q,     flags_d;
    logic             cond_pass_q, cond_pass_d;
    logic             br_taken_q,  br_taken_d;
    logic [CNT_W-1:0] fail_cnt_q,  fail_cnt_d;

    logic       flag_we;
    logic       fwd_sel;
    logic       f_n, f_z, f_c, f_v;
    logic       pass;
    logic       id_adv;

    // Flag write enable and EX->ID forwarding select; a stall blocks the
    // write but the forwarded values still reflect what EX is producing.
    always_comb begin
        flag_we = bus.ex_valid & bus.ex_s & ~bus.stall;
        fwd_sel = FWD_EN & bus.ex_valid & bus.ex_s;
        id_adv  = ~bus.stall & ~bus.flush;
    end

    // Effective flags seen by the ID condition check.
    always_comb begin
        if (fwd_sel) begin
            f_n = bus.alu_n;
            f_z = bus.alu_z;
            f_c = bus.alu_c;
            f_v = bus.alu_v;
        end else begin
            f_n = flags_q[3];
            f_z = flags_q[2];
            f_c = flags_q[1];
            f_v = flags_q[0];
        end
    end

    // ARM condition-field decode; 1111 (NV) is treated as never-execute.
    always_comb begin
        pass = 1'b0;
        case (bus.id_cond)
            4'b0000: pass = f_z;
            4'b0001: pass = ~f_z;
            4'b0010: pass = f_c;
            4'b0011: pass = ~f_c;
            4'b0100: pass = f_n;
            4'b0101: pass = ~f_n;
            4'b0110: pass = f_v;
            4'b0111: pass = ~f_v;
            4'b1000: pass = f_c & ~f_z;
            4'b1001: pass = ~f_c | f_z;
            4'b1010: pass = (f_n == f_v);
            4'b1011: pass = (f_n != f_v);
            4'b1100: pass = ~f_z & (f_n == f_v);
            4'b1101: pass = f_z | (f_n != f_v);
            4'b1110: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

    // Next-state for flags, ID/EX results and the fail counter.
    // Flush wins over stall for the ID/EX results; the counter only moves
    // on a normal advancing edge and sticks at all-ones.
    always_comb begin
        flags_d     = flags_q;
        cond_pass_d = cond_pass_q;
        br_taken_d  = br_taken_q;
        fail_cnt_d  = fail_cnt_q;

        if (flag_we) begin
            flags_d = {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
        end

        if (bus.flush) begin
            cond_pass_d = 1'b0;
            br_taken_d  = 1'b0;
        end else if (!bus.stall) begin
            cond_pass_d = bus.id_valid & pass;
            br_taken_d  = bus.id_valid & bus.id_is_branch & pass;
        end

        if (id_adv && bus.id_valid && !pass && (fail_cnt_q != {CNT_W{1'b1}})) begin
            fail_cnt_d = fail_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q     <= 4'b0000;
            cond_pass_q <= 1'b0;
            br_taken_q  <= 1'b0;
            fail_cnt_q  <= '0;
        end else begin
            flags_q     <= flags_d;
            cond_pass_q <= cond_pass_d;
            br_taken_q  <= br_taken_d;
            fail_cnt_q  <= fail_cnt_d;
        end
    end

    // Outputs; carry-in is the registered C so ADC/SBC never sees its own result.
    always_comb begin
        bus.flags_q     = flags_q;
        bus.alu_cin     = flags_q[1];
        bus.cond_pass_q = cond_pass_q;
        bus.br_taken_q  = br_taken_q;
        bus.fail_cnt    = fail_cnt_q;
    end

endmodule

// File: tb/tb_psr_cond_unit.sv
// Bench for psr_cond_unit: two instances share one stimulus stream.
// u_fwd uses forwarding and a 4-bit fail counter (saturates quickly);
// u_reg uses registered flags only with the default 16-bit counter.
module tb_psr_cond_unit;

    localparam int CW_F = 4;
    localparam int CW_R = 16;

    logic clk;
    logic reset_n;

    logic       alu_n, alu_z, alu_c, alu_v;
    logic       ex_valid, ex_s, id_valid, id_is_branch, stall, flush;
    logic [3:0] id_cond;

    psr_cond_unit_if #(.CNT_W(CW_F)) if_f ();
    psr_cond_unit_if #(.CNT_W(CW_R)) if_r ();

    assign if_f.alu_n        = alu_n;
    assign if_f.alu_z        = alu_z;
    assign if_f.alu_c        = alu_c;
    assign if_f.alu_v        = alu_v;
    assign if_f.ex_valid     = ex_valid;
    assign if_f.ex_s         = ex_s;
    assign if_f.id_valid     = id_valid;
    assign if_f.id_cond      = id_cond;
    assign if_f.id_is_branch = id_is_branch;
    assign if_f.stall        = stall;
    assign if_f.flush        = flush;

    assign if_r.alu_n        = alu_n;
    assign if_r.alu_z        = alu_z;
    assign if_r.alu_c        = alu_c;
    assign if_r.alu_v        = alu_v;
    assign if_r.ex_valid     = ex_valid;
    assign if_r.ex_s         = ex_s;
    assign if_r.id_valid     = id_valid;
    assign if_r.id_cond      = id_cond;
    assign if_r.id_is_branch = id_is_branch;
    assign if_r.stall        = stall;
    assign if_r.flush        = flush;

    psr_cond_unit #(.FWD_EN(1'b1), .CNT_W(CW_F)) u_fwd (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if_f.slave)
    );

    psr_cond_unit #(.FWD_EN(1'b0), .CNT_W(CW_R)) u_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if_r.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: flags are common, ID/EX results differ per instance (0=fwd, 1=reg).
    bit [3:0] m_flags;
    bit       m_pass [2];
    bit       m_br   [2];
    int       m_cnt  [2];
    int       m_max  [2];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ARM condition semantics written from the mnemonic meanings.
    function automatic bit arm_cond(input bit [3:0] c, input bit n, input bit z, input bit cy, input bit v);
        bit ge, gt, hi;
        ge = (n == v);
        gt = !z && ge;
        hi = cy && !z;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return hi;
            4'd9:  return !hi;
            4'd10: return ge;
            4'd11: return !ge;
            4'd12: return gt;
            4'd13: return !gt;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_flags = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            m_pass[i] = 1'b0;
            m_br[i]   = 1'b0;
            m_cnt[i]  = 0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".f.flags"}, {28'd0, if_f.flags_q},     {28'd0, m_flags});
        check({tag, ".f.cin"},   {31'd0, if_f.alu_cin},     {31'd0, m_flags[1]});
        check({tag, ".f.pass"},  {31'd0, if_f.cond_pass_q}, {31'd0, m_pass[0]});
        check({tag, ".f.br"},    {31'd0, if_f.br_taken_q},  {31'd0, m_br[0]});
        check({tag, ".f.cnt"},   {28'd0, if_f.fail_cnt},    m_cnt[0]);
        check({tag, ".r.flags"}, {28'd0, if_r.flags_q},     {28'd0, m_flags});
        check({tag, ".r.cin"},   {31'd0, if_r.alu_cin},     {31'd0, m_flags[1]});
        check({tag, ".r.pass"},  {31'd0, if_r.cond_pass_q}, {31'd0, m_pass[1]});
        check({tag, ".r.br"},    {31'd0, if_r.br_taken_q},  {31'd0, m_br[1]});
        check({tag, ".r.cnt"},   {16'd0, if_r.fail_cnt},    m_cnt[1]);
    endtask

    task automatic drive(input bit ev, input bit es, input bit [3:0] nzcv,
                         input bit iv, input bit [3:0] c, input bit br,
                         input bit st, input bit fl);
        ex_valid     = ev;
        ex_s         = es;
        {alu_n, alu_z, alu_c, alu_v} = nzcv;
        id_valid     = iv;
        id_cond      = c;
        id_is_branch = br;
        stall        = st;
        flush        = fl;
    endtask

    // One clock: predict from current inputs, clock, then compare everything.
    task automatic cycle(input string tag);
        bit [3:0] alu_f;
        bit [3:0] eff;
        bit [3:0] nxt_flags;
        bit       ok;
        bit       np [2];
        bit       nb [2];
        int       nc [2];
        alu_f = {alu_n, alu_z, alu_c, alu_v};
        nxt_flags = (ex_valid && ex_s && !stall) ? alu_f : m_flags;
        for (int i = 0; i < 2; i++) begin
            eff = (i == 0 && ex_valid && ex_s) ? alu_f : m_flags;
            ok  = arm_cond(id_cond, eff[3], eff[2], eff[1], eff[0]);
            np[i] = m_pass[i];
            nb[i] = m_br[i];
            nc[i] = m_cnt[i];
            if (flush) begin
                np[i] = 1'b0;
                nb[i] = 1'b0;
            end else if (!stall) begin
                np[i] = id_valid && ok;
                nb[i] = id_valid && id_is_branch && ok;
                if (id_valid && !ok && m_cnt[i] < m_max[i]) nc[i] = m_cnt[i] + 1;
            end
        end
        @(posedge clk);
        #1;
        m_flags = nxt_flags;
        for (int i = 0; i < 2; i++) begin
            m_pass[i] = np[i];
            m_br[i]   = nb[i];
            m_cnt[i]  = nc[i];
        end
        check_all(tag);
    endtask

    int cnt_before;
    bit [3:0] fw_conds [3] = '{4'b1011, 4'b1000, 4'b0110};

    initial begin
        m_max[0] = (1 << CW_F) - 1;
        m_max[1] = (1 << CW_R) - 1;
        model_reset();
        drive(0, 0, 4'b0000, 0, 4'b1110, 0, 0, 0);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("rst0");
        #2 reset_n = 1'b1;

        // Flag capture: SUB result 0x2C000035 gives N0 Z0 C1 V1.
        drive(1, 1, 4'b0011, 0, 4'b1110, 0, 0, 0);
        cycle("cap");
        check("cap_flags", {28'd0, if_f.flags_q}, 32'h3);
        check("cap_cin",   {31'd0, if_f.alu_cin}, 32'h1);
        drive(1, 0, 4'b1100, 0, 4'b1110, 0, 0, 0);
        cycle("nos");
        check("nos_flags", {28'd0, if_f.flags_q}, 32'h3);

        // Forwarding: flags 0000, EX writes 0011 while ID holds GE.
        drive(1, 1, 4'b0000, 0, 4'b1110, 0, 0, 0);
        cycle("clr");
        cnt_before = m_cnt[0];
        drive(1, 1, 4'b0011, 1, 4'b1010, 0, 0, 0);
        cycle("fw_ge");
        check("fw_ge_pass", {31'd0, if_f.cond_pass_q}, 32'h0);
        check("fw_ge_cnt",  {28'd0, if_f.fail_cnt}, cnt_before + 1);
        check("rg_ge_pass", {31'd0, if_r.cond_pass_q}, 32'h1);
        foreach (fw_conds[k]) begin
            drive(1, 1, 4'b0000, 0, 4'b1110, 0, 0, 0);
            cycle("clr_k");
            drive(1, 1, 4'b0011, 1, fw_conds[k], 0, 0, 0);
            cycle("fw_k");
            check("fw_k_pass", {31'd0, if_f.cond_pass_q}, 32'h1);
        end

        // Branch on EQ with Z set, then the same under flush.
        drive(1, 1, 4'b0100, 0, 4'b1110, 0, 0, 0);
        cycle("setz");
        drive(0, 0, 4'b0000, 1, 4'b0000, 1, 0, 0);
        cycle("br_eq");
        check("br_eq_taken", {31'd0, if_f.br_taken_q}, 32'h1);
        cnt_before = m_cnt[1];
        drive(0, 0, 4'b0000, 1, 4'b0000, 1, 0, 1);
        cycle("br_fl");
        check("br_fl_taken", {31'd0, if_f.br_taken_q}, 32'h0);
        check("br_fl_cnt",   {16'd0, if_r.fail_cnt}, cnt_before);

        // Stall: flag write and a failing NE must not disturb any state.
        drive(0, 0, 4'b0000, 1, 4'b1110, 0, 0, 0);
        cycle("pre_st");
        cnt_before = m_cnt[1];
        drive(1, 1, 4'b1011, 1, 4'b0001, 0, 1, 0);
        cycle("stall");
        check("st_flags", {28'd0, if_r.flags_q}, 32'h4);
        check("st_pass",  {31'd0, if_r.cond_pass_q}, 32'h1);
        check("st_cnt",   {16'd0, if_r.fail_cnt}, cnt_before);
        drive(1, 1, 4'b1011, 1, 4'b0001, 0, 0, 0);
        cycle("unstall");
        check("us_flags", {28'd0, if_r.flags_q}, 32'hB);

        // Saturation with the never-pass code 1111.
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 4'b0000, 1, 4'b1111, 0, 0, 0);
            cycle("sat");
        end
        check("sat_cnt", {28'd0, if_f.fail_cnt}, 32'd15);

        // Asynchronous reset mid-stall with flags 1111, no clock edge involved.
        drive(1, 1, 4'b1111, 1, 4'b1110, 1, 0, 0);
        cycle("set1111");
        check("pre_rst_flags", {28'd0, if_f.flags_q}, 32'hF);
        drive(1, 1, 4'b0101, 1, 4'b1111, 0, 1, 0);
        #1 reset_n = 1'b0;
        #1;
        model_reset();
        check_all("arst");
        #2 reset_n = 1'b1;

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), $urandom_range(0, 1),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0));
            cycle("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
